// File: rtl/common_pkg.sv
// Shared types, default widths and saturating-counter helper for the branch predictors.
package common;

  typedef logic [63:0] u64;

  localparam int DEF_IDX_BITS  = 10;
  localparam int DEF_CTR_BITS  = 2;
  localparam int DEF_HIST_BITS = 8;
  localparam int MAX_CTR_BITS  = 32;

  // Next value of a width-bit saturating counter; the result is never allowed to wrap.
  function automatic logic [MAX_CTR_BITS-1:0] sat_update(
    input logic [MAX_CTR_BITS-1:0] ctr,
    input logic                    taken,
    input int                      width
  );
    logic [MAX_CTR_BITS-1:0] max_v;
    max_v = (width >= MAX_CTR_BITS) ? '1 : ((MAX_CTR_BITS'(1) << width) - MAX_CTR_BITS'(1));
    if (taken) sat_update = (ctr == max_v) ? ctr : ctr + MAX_CTR_BITS'(1);
    else       sat_update = (ctr == '0)    ? ctr : ctr - MAX_CTR_BITS'(1);
  endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch-side prediction and execute-side feedback bundle of the gshare predictor.
interface gshare_predictor_if
  import common::*;
#(
  parameter int HIST_BITS = DEF_HIST_BITS
);
  // No backpressure: pred_valid and fb_valid are plain qualifiers consumed in the cycle they are
  // high; pred_taken/pred_hist are valid every cycle; fb_mispredict only counts when fb_valid is set.
  logic                 pred_valid;
  u64                   pred_pc;
  logic                 pred_taken;
  logic [HIST_BITS-1:0] pred_hist;
  logic                 fb_valid;
  u64                   fb_pc;
  logic [HIST_BITS-1:0] fb_hist;
  logic                 fb_taken;
  logic                 fb_mispredict;

  modport master (
    output pred_valid, pred_pc, fb_valid, fb_pc, fb_hist, fb_taken, fb_mispredict,
    input  pred_taken, pred_hist
  );

  modport slave (
    input  pred_valid, pred_pc, fb_valid, fb_pc, fb_hist, fb_taken, fb_mispredict,
    output pred_taken, pred_hist
  );
endinterface

// File: rtl/bp_sat_ctr_table.sv
// Array of saturating counters: one combinational read port, one registered update port.
module bp_sat_ctr_table
  import common::*;
#(
  parameter int IDX_BITS = DEF_IDX_BITS,
  parameter int CTR_BITS = DEF_CTR_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [CTR_BITS-1:0] rd_ctr,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);
  localparam int DEPTH = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] RESET_CTR = CTR_BITS'(1) << (CTR_BITS - 1);

  logic [CTR_BITS-1:0] ctr_q [DEPTH];
  logic [CTR_BITS-1:0] ctr_d [DEPTH];

  // Reads see the registered array, so a same-cycle update is not visible until the next cycle.
  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      ctr_d[wr_idx] = CTR_BITS'(sat_update(MAX_CTR_BITS'(ctr_q[wr_idx]), wr_taken, CTR_BITS));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= RESET_CTR;
    end else begin
      ctr_q <= ctr_d;
    end
  end
endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC xor speculative global history indexes a counter table.
// Optional GSHARE_PERF_CNT_EN adds branch and mispredict event counters.
module gshare_predictor
  import common::*;
#(
  parameter int IDX_BITS  = DEF_IDX_BITS,
  parameter int CTR_BITS  = DEF_CTR_BITS,
  parameter int HIST_BITS = DEF_HIST_BITS
) (
  input  logic               clk,
  input  logic               rst,
  gshare_predictor_if.slave  bp
`ifdef GSHARE_PERF_CNT_EN
  ,
  output u64                 perf_branches,
  output u64                 perf_mispredicts
`endif
);
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [IDX_BITS-1:0]  pidx, fidx;
  logic [CTR_BITS-1:0]  rd_ctr;

  assign pidx = bp.pred_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
  assign fidx = bp.fb_pc[IDX_BITS+1:2]   ^ IDX_BITS'(bp.fb_hist);

  bp_sat_ctr_table #(
    .IDX_BITS (IDX_BITS),
    .CTR_BITS (CTR_BITS)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pidx),
    .rd_ctr   (rd_ctr),
    .wr_en    (bp.fb_valid),
    .wr_idx   (fidx),
    .wr_taken (bp.fb_taken)
  );

  assign bp.pred_taken = rd_ctr[CTR_BITS-1];
  assign bp.pred_hist  = ghr_q;

  // Truncating casts drop the oldest bit, which also covers a one-bit history.
  always_comb begin
    ghr_d = ghr_q;
    if (bp.fb_valid && bp.fb_mispredict) begin
      ghr_d = HIST_BITS'({bp.fb_hist, bp.fb_taken});
    end else if (bp.pred_valid) begin
      ghr_d = HIST_BITS'({ghr_q, bp.pred_taken});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

`ifdef GSHARE_PERF_CNT_EN
  u64 perf_branches_q, perf_branches_d;
  u64 perf_mispredicts_q, perf_mispredicts_d;

  always_comb begin
    perf_branches_d    = perf_branches_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (bp.fb_valid) begin
      perf_branches_d = perf_branches_q + 64'd1;
      if (bp.fb_mispredict) perf_mispredicts_d = perf_mispredicts_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;
`endif
endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor to the per-PC 2-bit predictor.
- Indexes a table of saturating counters with PC XOR a speculative global history register (GHR).
- Counter width, table depth and history length are configurable.
- Exports the history snapshot used for each prediction so the backend can return it with resolution, for training and GHR repair on mispredict.
- Sits in the fetch stage; feedback comes from the execute/branch-resolve stage.

Parameters:
- IDX_BITS, 10, log2 of table entries (table depth = 2**IDX_BITS).
- CTR_BITS, 2, width of each saturating counter, >=1.
- HIST_BITS, 8, GHR length, 1..IDX_BITS.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- pred_valid  in  1  fetch is consuming a prediction this cycle (a conditional branch is being fetched).
- pred_pc  in  64  PC of the branch to predict (type u64).
- pred_taken  out  1  predicted direction.
- pred_hist  out  HIST_BITS  GHR value used to form this prediction's index.
- fb_valid  in  1  a conditional branch has resolved.
- fb_pc  in  64  PC of the resolved branch.
- fb_hist  in  HIST_BITS  pred_hist captured when that branch was predicted.
- fb_taken  in  1  actual direction.
- fb_mispredict  in  1  resolved direction differed from the prediction; qualified by fb_valid.

Behaviour:
- Reset (async, immediate on rst rising):
  - Every counter = 2**(CTR_BITS-1) (weakly taken).
  - GHR = 0.
  - Consequently pred_taken = 1 and pred_hist = 0 while in reset.
- Prediction (combinational, zero latency):
  - pidx = pred_pc[IDX_BITS+1:2] XOR zero-extended GHR.
  - pred_taken = MSB of table[pidx].
  - pred_hist = GHR.
  - Outputs are valid regardless of pred_valid.
- Training (registered, on the next clk edge):
  - Active only when fb_valid = 1.
  - fidx = fb_pc[IDX_BITS+1:2] XOR zero-extended fb_hist. Both ports use identical PC bits [IDX_BITS+1:2].
  - fb_taken = 1: increment table[fidx], saturating at all-ones.
  - fb_taken = 0: decrement table[fidx], saturating at zero.
  - Counters never wrap.
- GHR update (priority order, one per edge):
  1. fb_valid & fb_mispredict: GHR <= {fb_hist[HIST_BITS-2:0], fb_taken}. This repairs the history; any simultaneous pred_valid is discarded because fetch is being flushed.
  2. Else if pred_valid: GHR <= {GHR[HIST_BITS-2:0], pred_taken}, a speculative shift.
  3. Else: hold.
  - For HIST_BITS = 1, the shifted-out part is empty and GHR becomes the single new bit.
- Same-cycle read/write with pidx == fidx: the prediction sees the pre-update counter (read-before-write); the update lands at the edge.
- fb_mispredict without fb_valid: ignored.
- Reset mid-operation: all state is reinitialised immediately; no pending feedback is retained.
- No stall or handshake backpressure: every fb_valid is consumed in its cycle.

Optional Feature:
- Macro: GSHARE_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_branches (64) and perf_mispredicts (64), reset to 0.
  - perf_branches increments on each edge with fb_valid.
  - perf_mispredicts increments on each edge with fb_valid & fb_mispredict.
  - Both wrap modulo 2**64.
- Undefined: these ports and registers do not exist; the rest of the behaviour is identical.

Decomposition:
- In package common:
  - Typedef u64 (existing).
  - Localparam default widths.
  - Function sat_update(ctr, taken, width) returning the saturated next value.
- One natural sub-module: bp_sat_ctr_table. It holds the counter array, with one combinational read port, one synchronous update port and async reset. gshare_predictor wraps it with the index hashing and GHR logic.

Test Plan:
- Reset, then hold pred_pc = 0x1000 -> pred_taken = 1 and pred_hist = 0 for all PCs sampled.
- GHR = 0; three fb_valid, fb_taken = 0, fb_mispredict = 0 with fb_pc = 0x1000, fb_hist = 0 (CTR_BITS = 2) -> counter 10 -> 01 -> 00 -> 00 (saturates at 0), and pred_taken = 0 for pred_pc = 0x1000. Repeat with four fb_taken = 1 -> counter reaches 11 and holds.
- pred_valid for 4 cycles with predicted 1,1,0,1 -> GHR = 0b1101 (HIST_BITS = 8), and pred_hist follows each step.
- Same cycle: pred_valid = 1 and fb_valid = fb_mispredict = 1 with fb_hist = 0x5A, fb_taken = 1 -> next GHR = 0xB5 and the speculative shift is dropped.
- Index aliasing: pred_pc = 0x1004 with GHR = 0x01 hits the same entry as pc 0x1000 with hist 0x00. Train 0x1000/hist 0 to not-taken -> pred_taken = 0 for 0x1004/GHR 0x01. Also pidx == fidx in the same cycle -> old value is predicted, new value is visible the next cycle.
- Reset asserted mid-stream between clk edges -> outputs return to reset values without a clk edge. With GSHARE_PERF_CNT_EN, 5 feedbacks including 2 mispredicts -> perf_branches = 5, perf_mispredicts = 2, and both clear on reset.
